// File: rtl/imem_loader_pkg.sv
// Shared core definitions: instruction-memory base address, loader FSM states
// and the word-address helper used by the loader.
package imem_loader_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR  = 32'h0000_1000;
  localparam logic [31:0] LDR_BASE_ADDR   = IMEM_BASE_ADDR;
  localparam int          LDR_DEPTH_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ldr_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: 2-bit lane counter, 24-bit shift
// register, and a registered one-cycle word-complete pulse.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic        lane_full,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  r_lane;
  logic [23:0] r_sr;
  logic        r_vld;
  logic [31:0] r_word;

  assign lane_full = byte_fire && (r_lane == 2'd3);
  assign word_vld  = r_vld;
  assign word      = r_word;

  // Bytes enter at the top so the first byte lands in bits 7:0 of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= 2'd0;
      r_sr   <= 24'd0;
      r_vld  <= 1'b0;
      r_word <= 32'd0;
    end else begin
      r_vld <= 1'b0;
      if (clr) begin
        r_lane <= 2'd0;
        r_sr   <= 24'd0;
      end else if (byte_fire) begin
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) begin
          r_word <= {byte_data, r_sr};
          r_vld  <= 1'b1;
        end else begin
          r_sr <= {byte_data, r_sr[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into instruction
// memory, one write strobe per assembled 32-bit word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = LDR_BASE_ADDR,
  parameter int          DEPTH_WORDS = LDR_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH_WORDS);

  ldr_state_t  r_state, w_next;
  logic [15:0] r_len, r_word_count;
  logic [31:0] r_waddr;
  logic        r_done, r_err;
  logic        w_start_ok, w_hs, w_pack_fire, w_lane_full, w_we, w_ready, w_busy;
  logic [15:0] w_len_full;

  assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
  assign w_hs        = byte_valid && w_ready;
  assign w_pack_fire = w_hs && (r_state == ST_DATA);
  assign w_len_full  = {byte_data, r_len[7:0]};

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_start_ok),
    .byte_fire (w_pack_fire),
    .byte_data (byte_data),
    .lane_full (w_lane_full),
    .word_vld  (w_we),
    .word      (wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_LEN0;
      ST_LEN0: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_hs) w_next = ST_LEN1;
      end
      ST_LEN1: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_hs) begin
          if (w_len_full == 16'd0)                    w_next = ST_DONE;
          else if ({16'd0, w_len_full} > LP_DEPTH)    w_next = ST_ERR;
          else                                        w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        // word_count already holds the post-increment value during the write cycle.
        if (w_we && r_word_count == r_len) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= 16'd0;
      r_word_count <= 16'd0;
      r_waddr      <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_start_ok) begin
      r_len        <= 16'd0;
      r_word_count <= 16'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (r_state == ST_LEN0 && w_hs) r_len[7:0] <= byte_data;
      if (r_state == ST_LEN1 && w_hs) r_len <= w_len_full;
      if (w_lane_full) begin
        r_waddr      <= word_addr(BASE_ADDR, r_word_count);
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_next == ST_DONE && r_state != ST_DONE) r_done <= 1'b1;
      if (w_next == ST_ERR  && r_state != ST_ERR)  r_err  <= 1'b1;
    end
  end

  assign byte_ready = w_ready;
  assign busy       = w_busy;
  assign we         = w_we;
  assign waddr      = r_waddr;
  assign done       = r_done;
  assign error      = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts the write
// sequence; a per-cycle monitor checks every strobe against it.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, we, busy, done, error;
  logic [31:0] waddr, wdata;
  logic [15:0] word_count;

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int done_cyc = -100;
  logic prev_done = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Expected writes for the bytes actually delivered: only complete words of
  // an accepted length produce a strobe.
  task automatic model_load(input bq_t bs);
    int len, nw;
    len = (bs.size() >= 2) ? int'({bs[1], bs[0]}) : 0;
    if (len > 256) return;
    nw = (bs.size() >= 2) ? (bs.size() - 2) / 4 : 0;
    if (nw > len) nw = len;
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(32'h1000 + 32'(4 * i));
      exp_data.push_back({bs[2+4*i+3], bs[2+4*i+2], bs[2+4*i+1], bs[2+4*i]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("ready_eq_busy", {31'd0, byte_ready}, {31'd0, busy});
      if (we) begin
        last_we_cyc = cyc;
        if (exp_addr.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_we: got addr %h data %h expected no write", waddr, wdata);
        end else begin
          chk("waddr", waddr, exp_addr.pop_front());
          chk("wdata", wdata, exp_data.pop_front());
        end
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        fails++;
        $display("FAIL ready_timeout: got byte_ready 0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t bs, input bit toggle);
    foreach (bs[i]) begin
      send_byte(bs[i]);
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !error && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  bq_t prog, part, hdr0, hdrbad;

  initial begin
    prog   = '{8'h04, 8'h00, 8'hB7, 8'hE2, 8'hCD, 8'hAB, 8'h17, 8'h03, 8'h00, 8'h00,
               8'h93, 8'h03, 8'hC0, 8'hF9, 8'h13, 8'h04, 8'h20, 8'h03};
    hdr0   = '{8'h00, 8'h00};
    hdrbad = '{8'h01, 8'h01};
    part   = prog[0:7];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wc", {16'd0, word_count}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model against hand-decoded words.
    model_load(prog);
    chk("model_n", exp_addr.size(), 4);
    chk("model_d0", exp_data[0], 32'hABCDE2B7);
    chk("model_d1", exp_data[1], 32'h00000317);
    chk("model_d2", exp_data[2], 32'hF9C00393);
    chk("model_a3", exp_addr[3], 32'h0000100C);
    chk("model_d3", exp_data[3], 32'h03200413);

    // Back-to-back stream
    pulse_start();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    send_stream(prog, 1'b0);
    wait_end();
    chk("b2b_left", exp_addr.size(), 0);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_wc", {16'd0, word_count}, 32'd4);
    chk("b2b_ready", {31'd0, byte_ready}, 32'd0);
    chk("b2b_done_lat", done_cyc - last_we_cyc, 32'd1);
    chk("hold_waddr", waddr, 32'h0000100C);
    chk("hold_wdata", wdata, 32'h03200413);

    // Gappy stream
    model_load(prog);
    pulse_start();
    chk("tog_done_clr", {31'd0, done}, 32'd0);
    chk("tog_wc_clr", {16'd0, word_count}, 32'd0);
    send_stream(prog, 1'b1);
    wait_end();
    chk("tog_left", exp_addr.size(), 0);
    chk("tog_done", {31'd0, done}, 32'd1);
    chk("tog_wc", {16'd0, word_count}, 32'd4);
    chk("tog_done_lat", done_cyc - last_we_cyc, 32'd1);

    // Zero length
    pulse_start();
    send_stream(hdr0, 1'b0);
    wait_end();
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_wc", {16'd0, word_count}, 32'd0);
    chk("zero_err", {31'd0, error}, 32'd0);

    // Oversized length, then recovery
    pulse_start();
    send_stream(hdrbad, 1'b0);
    wait_end();
    chk("big_err", {31'd0, error}, 32'd1);
    chk("big_done", {31'd0, done}, 32'd0);
    chk("big_ready", {31'd0, byte_ready}, 32'd0);
    chk("big_wc", {16'd0, word_count}, 32'd0);
    pulse_start();
    chk("rec_busy", {31'd0, busy}, 32'd1);
    chk("rec_err", {31'd0, error}, 32'd0);
    chk("rec_ready", {31'd0, byte_ready}, 32'd1);

    // Abort by reset after six data bytes
    model_load(part);
    send_stream(part, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_left", exp_addr.size(), 0);
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_waddr", waddr, 32'd0);
    chk("abort_wdata", wdata, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wc", {16'd0, word_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_load(prog);
    pulse_start();
    send_stream(prog, 1'b0);
    wait_end();
    chk("rerun_left", exp_addr.size(), 0);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_wc", {16'd0, word_count}, 32'd4);

    // start during DATA is ignored
    model_load(prog);
    pulse_start();
    send_stream(prog[0:6], 1'b0);
    pulse_start();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_wc", {16'd0, word_count}, 32'd1);
    send_stream(prog[7:17], 1'b0);
    wait_end();
    chk("mid_left", exp_addr.size(), 0);
    chk("mid_done", {31'd0, done}, 32'd1);
    chk("mid_wc_end", {16'd0, word_count}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, byte address of the first program word written.
REQ-002 Parameter DEPTH_WORDS, default 256, maximum number of words accepted in one load.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 Port byte_valid  input  1  source has a byte on byte_data.
REQ-007 Port byte_data  input  8  stream byte.
REQ-008 Port byte_ready  output  1  loader accepts a byte this cycle; handshake = byte_valid & byte_ready.
REQ-009 Port we  output  1  one-cycle write strobe toward the instruction memory write port.
REQ-010 Port waddr  output  32  byte address of the word being written.
REQ-011 Port wdata  output  32  assembled instruction word.
REQ-012 Port busy  output  1  high while in LEN0, LEN1 or DATA.
REQ-013 Port done  output  1  sticky: load completed successfully.
REQ-014 Port error  output  1  sticky: header length exceeded DEPTH_WORDS.
REQ-015 Port word_count  output  16  number of words written in the current or last load.

Function
REQ-016 FSM states SHALL be IDLE, LEN0, LEN1, DATA, DONE, ERR.
REQ-017 start in IDLE/DONE/ERR SHALL move to LEN0 next cycle, clear done, error and word_count.
REQ-018 start while busy SHALL be ignored.
REQ-019 byte_ready SHALL be high exactly in LEN0, LEN1, DATA; low in IDLE, DONE, ERR.
REQ-020 Stream format: 16-bit little-endian word length (LEN0 = low byte, LEN1 = high byte), then length words, each 4 bytes little-endian (first byte -> bits 7:0).
REQ-021 After the LEN1 handshake: length 0 -> DONE; length > DEPTH_WORDS -> ERR; otherwise -> DATA.
REQ-022 Bytes SHALL be counted with a 2-bit lane counter wrapping 3 -> 0; no handshake, no advance.
REQ-023 On the 4th-byte handshake in cycle N, we SHALL be 1 in cycle N+1 only, with wdata = assembled word and waddr = BASE_ADDR + 4*word_count (pre-increment value).
REQ-024 word_count SHALL increment in the same cycle we is asserted.
REQ-025 byte_ready SHALL stay high during the write cycle; a byte accepted then goes into lane 0 of the next word (full throughput, one byte/cycle).
REQ-026 When the last word's we is issued, the FSM SHALL enter DONE in that same cycle-edge; done rises with we's cycle+1 and byte_ready is low from that cycle.
REQ-027 On entering ERR, error SHALL be 1 and no further we issued.
REQ-028 waddr and wdata SHALL hold their last values when we is low; waddr arithmetic is 32-bit, no wrap check beyond DEPTH_WORDS.
REQ-029 byte_valid while byte_ready is low SHALL be ignored without side effect.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, word_count=0, lane counter and length cleared.
REQ-031 Reset mid-load SHALL abort without issuing any further we; partial word discarded.

Structure
REQ-032 FSM state encoding and the default BASE_ADDR constant SHALL live in the shared core package alongside the instruction-memory base address so both agree.
REQ-033 Byte-to-word assembly (lane counter, shift register, word-complete pulse) SHALL be one sub-module, imem_word_packer; the top holds FSM, length and address logic.

Verification
REQ-034 Stream 04 00 B7 E2 CD AB 17 03 00 00 93 03 C0 F9 13 04 20 03 back-to-back -> we pulses write 0xABCDE2B7@0x1000, 0x00000317@0x1004, 0xF9C00393@0x1008, 0x03200413@0x100C; done=1, word_count=4.
REQ-035 Same stream with byte_valid toggling every other cycle -> identical writes, no extra/missing we.
REQ-036 Header 00 00 -> DONE immediately after LEN1, no we, done=1, word_count=0.
REQ-037 Header 01 01 (257 > 256) -> ERR, error=1, byte_ready=0, no we; subsequent start recovers to LEN0 with error cleared.
REQ-038 rst_n pulsed low after 6 data bytes -> all outputs zero at once; new start plus full stream writes from 0x1000 correctly.
REQ-039 start asserted during DATA -> ignored; load completes unchanged.
